sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
Parametrised single-clock FIFO that succeeds the basic counter-based FIFO. It adds concurrent read and write in the same cycle, a selectable read mode (standard registered or first-word-fall-through), programmable almost-full and almost-empty thresholds, a fill-level output, and overflow/underflow error pulses. It is the buffering primitive for datapath blocks and for the FIFO verification environment.

Parameters:
DATA_WIDTH, 8, width of data word
DEPTH, 16, number of entries; power of two, >= 4
FWFT, 0, 0 = standard read (data one cycle after rd); 1 = first-word-fall-through
AF_THRESH, DEPTH-2, almost_full asserted when level >= AF_THRESH
AE_THRESH, 2, almost_empty asserted when level <= AE_THRESH

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr  in  1  write request
din  in  DATA_WIDTH  write data
rd  in  1  read request (FWFT=1: acknowledge/pop of head word)
dout  out  DATA_WIDTH  read data
valid  out  1  dout holds a valid word
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH
level  out  $clog2(DEPTH)+1  current number of stored words
overflow  out  1  one-cycle pulse: wr while full
underflow  out  1  one-cycle pulse: rd while empty

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low. While rst_n=0: pointers=0, level=0, dout=0, valid=0, overflow=0, underflow=0. Therefore empty=1, almost_empty=1, full=0, almost_full=0 (AF_THRESH>0). Memory contents are not reset. A reset mid-operation discards all stored words immediately. Deassertion is synchronised externally.
- Pointers: wptr and rptr are $clog2(DEPTH)+1 bits wide. The memory index is ptr[$clog2(DEPTH)-1:0], and wrap-around is natural binary roll-over.
- Accept rules, evaluated on the registered flags:
  - wr_ok = wr & !full
  - rd_ok = rd & !empty
- Write: when wr_ok, mem[wptr] <= din and wptr++.
- Read: when rd_ok, rptr++.
- Level update: +1 if wr_ok only, -1 if rd_ok only, unchanged if both or neither.
- Simultaneous rd & wr:
  - Not full and not empty: both succeed and level holds.
  - Empty: only the write succeeds, and underflow pulses.
  - Full: only the read succeeds, and overflow pulses.
- Error pulses: overflow = registered (wr & full); underflow = registered (rd & empty). Each is high for exactly one cycle per offending request cycle. Pointers and level are unaffected.
- Flags: full, empty, almost_full and almost_empty are combinational from the level register. They update the cycle after the causing edge.
- FWFT=0 (standard read):
  - On rd_ok, dout <= mem[rptr] and valid <= 1, so read latency is 1 cycle.
  - Otherwise valid <= 0 and dout holds its last value.
- FWFT=1 (first-word-fall-through):
  - dout = mem[rptr] combinationally, and valid = !empty.
  - A word written in cycle N is visible on dout in cycle N+1.
  - rd_ok pops the head; the next word appears in the same cycle the pointer advances.
- Write-to-read: a word written at edge N cannot be read before edge N+1, because empty is sampled from the registered level.
- Threshold legality: checked by assertion at elaboration, AE_THRESH < AF_THRESH <= DEPTH.

Decomposition:
- Package sync_fifo_pkg holds:
  - function ptr_w(depth), returning $clog2(depth)+1
  - a read-mode enum: FIFO_STD=0, FIFO_FWFT=1
  - a level_t typedef helper
- One sub-module, sync_fifo_mem: a simple dual-port register array with synchronous write and asynchronous read. The top level owns pointers, level, flags and the read-mode muxing.
- A new fifo_if interface variant carries the added flag and level signals for the bench.

Test Plan:
1. Reset then 16 writes (0x00..0x0F), no reads. Required: level counts 1..16; almost_full rises when level=14; full=1 after the 16th write. A 17th wr gives one overflow pulse, and level stays 16.
2. FWFT=0: after scenario 1, apply 16 reads. Required: dout = 0x00..0x0F, each one cycle after its rd with valid=1; empty=1 at the end. A further rd gives an underflow pulse and valid=0.
3. Concurrent traffic: fill 8 words, then assert rd&wr for 20 cycles with din incrementing. Required: level stays 8, data order is preserved, no flag toggles, and wrap-around passes index 15→0 correctly.
4. Boundary concurrency: rd&wr while empty → only the write is taken, level=1, underflow pulses. rd&wr while full → only the read is taken, level=15, overflow pulses.
5. FWFT=1: write 0xA5 at cycle N. Required: dout=0xA5 with valid=1 at N+1 before any rd; rd pops it and valid=0 the next cycle.
6. Assert rst_n=0 asynchronously mid-burst with level=9. Required: empty=1, level=0, valid=0 immediately with no clk edge; after release, the first read returns the first post-reset write.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared types and helpers for the sync_fifo_flags FIFO family.
//   ptr_w(depth) : pointer / level width for a FIFO of the given depth
//   read_mode_e  : FIFO_STD (registered read) or FIFO_FWFT (fall-through)
//   level_t      : wide unsigned carrier used to compare a level against
//                  integer thresholds without width juggling
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } read_mode_e;

    localparam int LEVEL_T_W = 32;
    typedef logic [LEVEL_T_W-1:0] level_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_if.sv
// -----------------------------------------------------------------------------
// fifo_if
// Bundle of the FIFO request, data, flag and level signals, used by the
// verification environment to wire up a sync_fifo_flags instance.
//   wr/rd/din              : request side
//   dout/valid             : read data side
//   full/empty/almost_*    : status flags
//   level                  : fill level
//   overflow/underflow     : error pulses
// -----------------------------------------------------------------------------
interface fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEVEL_W    = 5
);
    logic                  wr;
    logic                  rd;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [LEVEL_W-1:0]    level;
    logic                  overflow;
    logic                  underflow;
endinterface

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// Simple dual-port register array: synchronous write, asynchronous read.
// Contents are never reset.
//   clk   : clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data (combinational)
// -----------------------------------------------------------------------------
module sync_fifo_mem #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
// Single-clock FIFO with concurrent read/write, standard or fall-through read
// mode, programmable almost-full / almost-empty thresholds, a fill level and
// overflow / underflow error pulses.
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   wr, din      : write request and data
//   rd           : read request (fall-through mode: pop of the head word)
//   dout, valid  : read data and its qualifier
//   full, empty, almost_full, almost_empty : flags decoded from level
//   level        : number of stored words
//   overflow     : one-cycle pulse after a write while full
//   underflow    : one-cycle pulse after a read while empty
// -----------------------------------------------------------------------------
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    parameter  int FWFT       = 0,
    parameter  int AF_THRESH  = DEPTH - 2,
    parameter  int AE_THRESH  = 2,
    localparam int PW         = ptr_w(DEPTH),
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PW-1:0]         level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam read_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH && DEPTH >= 4 &&
          (DEPTH & (DEPTH - 1)) == 0)) begin : g_bad_params
        $error("sync_fifo_flags: illegal DEPTH / threshold parameters");
    end

    logic [PW-1:0]         wptr_q;
    logic [PW-1:0]         rptr_q;
    logic [PW-1:0]         level_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] mem_rdata;
    level_t                level_ext;

    // The pointer MSBs only disambiguate wrap laps; occupancy is tracked by
    // level_q, so nothing downstream consumes them.
    logic unused_ptr_msb;
    assign unused_ptr_msb = wptr_q[PW-1] ^ rptr_q[PW-1];

    // Flags decode straight from the level register, so a word written at
    // edge N is only readable from edge N+1 onwards.
    assign level_ext    = level_t'(level_q);
    assign full         = (level_ext == level_t'(DEPTH));
    assign empty        = (level_q == '0);
    assign almost_full  = (level_ext >= level_t'(AF_THRESH));
    assign almost_empty = (level_ext <= level_t'(AE_THRESH));
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    assign wr_ok = wr & ~full;
    assign rd_ok = rd & ~empty;

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wptr_q[AW-1:0]),
        .wdata (din),
        .raddr (rptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            ovf_q <= wr & full;
            udf_q <= rd & empty;
            if (wr_ok) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (rd_ok) begin
                rptr_q <= rptr_q + PW'(1);
            end
            if (wr_ok && !rd_ok) begin
                level_q <= level_q + PW'(1);
            end else if (rd_ok && !wr_ok) begin
                level_q <= level_q - PW'(1);
            end
        end
    end

    if (MODE == FIFO_STD) begin : g_std
        logic [DATA_WIDTH-1:0] dout_p1;
        logic                  vld_p1;

        // ---- read stage p1: head word registered on an accepted read ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_p1 <= '0;
                vld_p1  <= 1'b0;
            end else begin
                vld_p1 <= rd_ok;
                if (rd_ok) begin
                    dout_p1 <= mem_rdata;
                end
            end
        end

        assign dout  = dout_p1;
        assign valid = vld_p1;
    end else begin : g_fwft
        // Head word is presented directly; forced to zero while empty so
        // that reset and idle states show a clean bus.
        assign valid = ~empty;
        assign dout  = empty ? '0 : mem_rdata;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int LW    = 5;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_if #(.DATA_WIDTH(DW), .LEVEL_W(LW)) f ();

    logic [DW-1:0] dout_f;
    logic          valid_f, full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
    logic [LW-1:0] level_f;

    sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr           (f.wr),
        .din          (f.din),
        .rd           (f.rd),
        .dout         (f.dout),
        .valid        (f.valid),
        .full         (f.full),
        .empty        (f.empty),
        .almost_full  (f.almost_full),
        .almost_empty (f.almost_empty),
        .level        (f.level),
        .overflow     (f.overflow),
        .underflow    (f.underflow)
    );

    sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr           (f.wr),
        .din          (f.din),
        .rd           (f.rd),
        .dout         (dout_f),
        .valid        (valid_f),
        .full         (full_f),
        .empty        (empty_f),
        .almost_full  (af_f),
        .almost_empty (ae_f),
        .level        (level_f),
        .overflow     (ovf_f),
        .underflow    (udf_f)
    );

    // Reference model: a queue of stored words plus the standard-mode
    // output register contents.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_valid;
    logic          m_ovf;
    logic          m_udf;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        logic [DW-1:0] head;
        n    = q.size();
        head = (n > 0) ? q[0] : '0;
        chk("level",        32'(f.level),        32'(n));
        chk("full",         32'(f.full),         32'(n == DEPTH));
        chk("empty",        32'(f.empty),        32'(n == 0));
        chk("almost_full",  32'(f.almost_full),  32'(n >= AF));
        chk("almost_empty", 32'(f.almost_empty), 32'(n <= AE));
        chk("overflow",     32'(f.overflow),     32'(m_ovf));
        chk("underflow",    32'(f.underflow),    32'(m_udf));
        chk("std_valid",    32'(f.valid),        32'(m_valid));
        chk("std_dout",     32'(f.dout),         32'(m_dout));
        chk("fwft_level",   32'(level_f),        32'(n));
        chk("fwft_full",    32'(full_f),         32'(n == DEPTH));
        chk("fwft_ovf",     32'(ovf_f),          32'(m_ovf));
        chk("fwft_udf",     32'(udf_f),          32'(m_udf));
        chk("fwft_valid",   32'(valid_f),        32'(n > 0));
        chk("fwft_dout",    32'(dout_f),         32'(head));
    endtask

    task automatic model_reset();
        q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    // Drive one cycle of requests, advance the model across the edge and
    // compare all outputs 1 time unit later.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        int n;
        bit wok, rok;
        f.wr  = w;
        f.rd  = r;
        f.din = d;
        @(posedge clk);
        n     = q.size();
        wok   = w && (n < DEPTH);
        rok   = r && (n > 0);
        m_ovf = w && (n == DEPTH);
        m_udf = r && (n == 0);
        m_valid = rok;
        if (rok) m_dout = q.pop_front();
        if (wok) q.push_back(d);
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        f.wr  = 1'b0;
        f.rd  = 1'b0;
        f.din = '0;
        model_reset();

        // Reset state
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full, then one rejected write
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'(i));
        step(1'b1, 1'b0, 8'hEE);
        chk("ovf_level_held", 32'(f.level), 32'(DEPTH));
        step(1'b0, 1'b0, 8'h00);

        // Drain in order, then one rejected read
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Concurrent traffic across the index wrap
        for (int i = 0; i < 8; i++)  step(1'b1, 1'b0, DW'(8'h20 + i));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, DW'(8'h30 + i));
        for (int i = 0; i < 8; i++)  step(1'b0, 1'b1, 8'h00);

        // Boundary concurrency: empty, then full
        step(1'b1, 1'b1, 8'h55);
        step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'(8'h60 + i));
        step(1'b1, 1'b1, 8'h77);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'h00);

        // Fall-through: word visible before any read, popped by rd
        step(1'b1, 1'b0, 8'hA5);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Asynchronous reset mid-burst with nine words stored
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, DW'(8'h90 + i));
        f.wr = 1'b0;
        f.rd = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h3C);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Randomized traffic in phases with different write/read bias
        for (int ph = 0; ph < 4; ph++) begin
            int wp, rp;
            case (ph)
                0: begin wp = 70; rp = 30; end
                1: begin wp = 30; rp = 70; end
                2: begin wp = 50; rp = 50; end
                default: begin wp = 90; rp = 60; end
            endcase
            for (int i = 0; i < 120; i++) begin
                step(($urandom_range(99) < wp), ($urandom_range(99) < rp), DW'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
